// File: rtl/program_store.sv
// Eight-entry writable instruction store with a valid/ready byte loader feeding the CPU.
// Optional trailing-checksum verification is compiled in with PROGRAM_STORE_CHECKSUM_EN.
module program_store #(
   parameter int DEPTH     = 8,
   parameter int ADDR_BITS = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 load_start,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [7:0]           load_data,
   input  logic                 load_last,
   input  logic [ADDR_BITS-1:0] pc,
   output logic [3:0]           opcode,
   output logic [3:0]           arg,
   output logic                 cpu_hold,
   output logic [3:0]           loaded_count,
   output logic                 load_error
);

   // state | meaning
   // IDLE  | no load in progress, CPU free to step
   // LOAD  | accepting data words from address 0 upward
   // CHECK | accepting the single trailing checksum word
   typedef enum logic [1:0] {
      IDLE,
      LOAD
`ifdef PROGRAM_STORE_CHECKSUM_EN
      , CHECK
`endif
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(DEPTH - 1);

   state_t               state, state_nxt;
   logic [7:0]           mem [DEPTH];
   logic [ADDR_BITS-1:0] wr_ptr;
   logic                 accept;
   logic                 data_done;

   assign accept    = load_valid & load_ready;
   assign data_done = load_last | (loaded_count == LAST_CNT);

   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      cpu_hold   = 1'b0;
      case (state)
         IDLE: begin
            if (load_start) state_nxt = LOAD;
         end
         LOAD: begin
            load_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (load_start) begin
               state_nxt = LOAD;
            end else if (accept && data_done) begin
`ifdef PROGRAM_STORE_CHECKSUM_EN
               state_nxt = CHECK;
`else
               state_nxt = IDLE;
`endif
            end
         end
`ifdef PROGRAM_STORE_CHECKSUM_EN
         CHECK: begin
            load_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (load_start)  state_nxt = LOAD;
            else if (accept) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         loaded_count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else begin
         state <= state_nxt;
         // A start pulse wins over any word presented in the same cycle.
         if (load_start) begin
            wr_ptr       <= '0;
            loaded_count <= '0;
         end else if (accept && state == LOAD) begin
            mem[wr_ptr]  <= load_data;
            wr_ptr       <= wr_ptr + 1'b1;
            loaded_count <= loaded_count + 4'd1;
         end
      end
   end

`ifdef PROGRAM_STORE_CHECKSUM_EN
   logic [3:0] acc;
   logic       error_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         error_q <= 1'b0;
      end else if (load_start) begin
         acc     <= '0;
         error_q <= 1'b0;
      end else if (accept && state == LOAD) begin
         acc <= acc ^ load_data[7:4] ^ load_data[3:0];
      end else if (accept && state == CHECK) begin
         error_q <= (load_data[3:0] != acc);
      end
   end

   assign load_error = error_q;
`else
   assign load_error = 1'b0;
`endif

   assign opcode = mem[pc][7:4];
   assign arg    = mem[pc][3:0];

endmodule

// File: tb/tb_program_store.sv
// Directed bench for program_store: a word-level load model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_program_store;
   logic       clock = 1'b0;
   logic       reset;
   logic       load_start, load_valid, load_last;
   logic [7:0] load_data;
   logic [2:0] pc;
   logic       load_ready, cpu_hold, load_error;
   logic [3:0] opcode, arg, loaded_count;

   int checks   = 0;
   int failures = 0;

   program_store #(.DEPTH(8), .ADDR_BITS(3)) dut (
      .clock(clock), .reset(reset), .load_start(load_start), .load_valid(load_valid),
      .load_ready(load_ready), .load_data(load_data), .load_last(load_last), .pc(pc),
      .opcode(opcode), .arg(arg), .cpu_hold(cpu_hold), .loaded_count(loaded_count),
      .load_error(load_error)
   );

   always #5 clock = ~clock;

`ifdef PROGRAM_STORE_CHECKSUM_EN
   localparam bit CKSUM = 1'b1;
`else
   localparam bit CKSUM = 1'b0;
`endif

   // Model: a load is "busy" from start until its last word (data or checksum) is taken.
   logic [7:0] m_mem [8] = '{default: 8'h00};
   bit         m_busy    = 0;
   bit         m_want_ck = 0;
   int         m_count   = 0;
   logic [3:0] m_acc     = 4'h0;
   bit         m_err     = 0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
         m_busy = 0; m_want_ck = 0; m_count = 0; m_acc = 4'h0; m_err = 0;
      end else if (load_start) begin
         m_busy = 1; m_want_ck = 0; m_count = 0; m_acc = 4'h0; m_err = 0;
      end else if (m_busy && load_valid) begin
         if (m_want_ck) begin
            m_err = (load_data[3:0] != m_acc);
            m_busy = 0; m_want_ck = 0;
         end else begin
            m_mem[m_count] = load_data;
            m_count++;
            m_acc = m_acc ^ load_data[7:4] ^ load_data[3:0];
            if (load_last || m_count == 8) begin
               if (CKSUM) m_want_ck = 1;
               else       m_busy = 0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      chk("opcode",       {4'h0, opcode},       {4'h0, m_mem[pc][7:4]});
      chk("arg",          {4'h0, arg},          {4'h0, m_mem[pc][3:0]});
      chk("cpu_hold",     {7'h0, cpu_hold},     {7'h0, m_busy});
      chk("load_ready",   {7'h0, load_ready},   {7'h0, m_busy});
      chk("loaded_count", {4'h0, loaded_count}, 8'(m_count));
      chk("load_error",   {7'h0, load_error},   {7'h0, m_err});
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      load_valid = 1'b1; load_data = d; load_last = last;
      tick();
      load_valid = 1'b0; load_last = 1'b0; load_data = 8'h00;
   endtask

   task automatic send_cksum();
      if (CKSUM) send({4'h0, m_acc}, 1'b0);
   endtask

   initial begin
      reset = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_data = 0; pc = 0;
      tick();
      reset = 1'b0;

      // reset contents
      for (int i = 0; i < 8; i++) begin
         pc = 3'(i);
         #1 chk("reset_read", {opcode, arg}, 8'h00);
         tick();
      end
      chk("reset_count", {4'h0, loaded_count}, 8'h00);

      // short load ending on load_last; a stray load_last without valid is ignored
      start();
      send(8'hA5, 1'b0);
      load_last = 1'b1; tick(); load_last = 1'b0;
      send(8'h30, 1'b0);
      send(8'h71, 1'b1);
      chk("short_count", {4'h0, loaded_count}, 8'h03);
      if (!CKSUM) chk("short_hold", {7'h0, cpu_hold}, 8'h00);
      pc = 3'd1;
      #1 chk("short_pc1", {opcode, arg}, 8'h30);
      pc = 3'd2;
      #1 chk("short_pc2", {opcode, arg}, 8'h71);
      send_cksum();
      tick();

      // full load, no load_last; extra valid afterwards must be ignored
      start();
      for (int i = 0; i < 8; i++) send(8'h10 + 8'(i * 17), 1'b0);
      send_cksum();
      chk("full_count", {4'h0, loaded_count}, 8'h08);
      chk("full_ready", {7'h0, load_ready}, 8'h00);
      send(8'hFF, 1'b1);
      pc = 3'd7;
      #1 chk("full_pc7", {opcode, arg}, 8'h87);
      // valid held while idle
      load_valid = 1'b1; load_data = 8'h5A;
      tick(); tick();
      load_valid = 1'b0;

      // restart after two words; data in the start cycle is discarded
      start();
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      load_valid = 1'b1; load_data = 8'hEE;
      start();
      load_valid = 1'b0;
      send(8'h11, 1'b1);
      chk("restart_count", {4'h0, loaded_count}, 8'h01);
      pc = 3'd0;
      #1 chk("restart_pc0", {opcode, arg}, 8'h11);
      pc = 3'd1;
      #1 chk("restart_pc1", {opcode, arg}, 8'h33);
      send_cksum();
      tick();

`ifdef PROGRAM_STORE_CHECKSUM_EN
      start();
      send(8'hA5, 1'b0);
      send(8'h30, 1'b1);
      send(8'h0C, 1'b0);
      chk("ck_good", {7'h0, load_error}, 8'h00);
      start();
      send(8'hA5, 1'b0);
      send(8'h30, 1'b1);
      send(8'h0D, 1'b0);
      chk("ck_bad", {7'h0, load_error}, 8'h01);
      tick(); tick();
      chk("ck_sticky", {7'h0, load_error}, 8'h01);
      start();
      chk("ck_clear", {7'h0, load_error}, 8'h00);
      send(8'h00, 1'b1);
      send_cksum();
`endif

      // asynchronous reset mid-load
      start();
      for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 1'b0);
      reset = 1'b1;
      #1;
      chk("rst_hold",  {7'h0, cpu_hold},   8'h00);
      chk("rst_ready", {7'h0, load_ready}, 8'h00);
      chk("rst_count", {4'h0, loaded_count}, 8'h00);
      for (int i = 0; i < 8; i++) begin
         pc = 3'(i);
         #0.1 chk("rst_read", {opcode, arg}, 8'h00);
      end
      tick();
      reset = 1'b0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/program_store.md
# program_store

Eight-entry instruction store and loader that sits directly upstream of the four-bit CPU. It replaces the CPU's hard-wired program with a writable memory. A byte-wide valid/ready loader fills the memory from address 0, and an asynchronous read port returns `{opcode, arg}` for the CPU's current `pc`. While a load is in progress, `cpu_hold` tells the step logic to suppress CPU steps.

## Interface
- `DEPTH`, 8: number of instruction words; must equal 2**`ADDR_BITS`
- `ADDR_BITS`, 3: width of `pc` and of the write pointer
- `clock` in 1: loader clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state and memory
- `load_start` in 1: single-cycle pulse that begins a load at address 0
- `load_valid` in 1: `load_data` is presented this cycle
- `load_ready` out 1: store accepts a word this cycle
- `load_data` in 8: instruction word; [7:4] is the opcode, [3:0] is the argument
- `load_last` in 1: qualifies the accepted word as the final data word
- `pc` in `ADDR_BITS`: CPU program counter (read address)
- `opcode` out 4: `mem[pc][7:4]`, combinational
- `arg` out 4: `mem[pc][3:0]`, combinational
- `cpu_hold` out 1: high while a load is in progress
- `loaded_count` out 4: number of data words written by the most recent load (0..8)
- `load_error` out 1: checksum mismatch flag; see Configuration

## Operation
- States: IDLE, LOAD, CHECK. CHECK exists only when the checksum feature is compiled in.
- Accept is `load_valid & load_ready`. Words are written only on accept.
- IDLE:
  - `load_ready`=0, `cpu_hold`=0.
  - `load_start` → LOAD; `wr_ptr`←0, `loaded_count`←0, `load_error`←0, checksum accumulator←0.
- LOAD:
  - `load_ready`=1, `cpu_hold`=1.
  - On accept: `mem[wr_ptr]`←`load_data`, `wr_ptr`←`wr_ptr`+1, `loaded_count`←`loaded_count`+1, accumulator ^= `load_data[7:4] ^ load_data[3:0]`.
  - An accept with `load_last`=1, or the accept that makes `loaded_count`=`DEPTH`, ends the data phase. The next state is CHECK if the feature is enabled, otherwise IDLE.
- CHECK:
  - `load_ready`=1, `cpu_hold`=1.
  - Accepts exactly one word; only `load_data[3:0]` is compared with the accumulator.
  - `load_error`←(mismatch). State → IDLE.
- Addresses not written by a load keep their previous contents.
- `pc` is a full `ADDR_BITS` value, so all reads are in range. `wr_ptr` never wraps because the load ends at `DEPTH` words.
- `load_error` is sticky until the next `load_start` or `reset`.

## Timing
- Reset values:
  - state IDLE, `wr_ptr`=0, `loaded_count`=0, `load_error`=0, all `mem` entries 8'h00.
  - Therefore `opcode`=0, `arg`=0, `load_ready`=0, `cpu_hold`=0.
- `load_start` sampled at edge N: `load_ready` and `cpu_hold` are high from after edge N.
- A `load_valid` in the same cycle as `load_start` in IDLE is not accepted.
- A word accepted at edge N appears on `opcode`/`arg` after edge N when `pc` addresses it. Write-to-read latency is 0 cycles after the edge; there is no read pipeline.
- `cpu_hold` falls after the edge that accepts the final word: the last data word, or the checksum word when enabled.
- `load_start` in LOAD or CHECK restarts the load. `wr_ptr`, `loaded_count` and the accumulator are zeroed, any data accepted in that cycle is discarded, and the state becomes LOAD.
- `load_last` without an accept is ignored.
- `reset` asserted mid-load: memory and state are cleared immediately, asynchronously, with no partial retention.
- `load_valid` held high in IDLE: no effect.

## Configuration
- Macro: `PROGRAM_STORE_CHECKSUM_EN`.
- Defined:
  - CHECK state present.
  - A trailing checksum word is required after the data words: the XOR of all opcode and argument nibbles.
  - `load_error` reports a mismatch.
- Undefined:
  - No CHECK state and no accumulator.
  - The load ends on the final data word.
  - `load_error` is tied to 0.

## Test plan
- Reset then read `pc`=0..7 → `opcode`=0, `arg`=0 at every address; `cpu_hold`=0, `load_ready`=0, `loaded_count`=0.
- Start a load, send 8'hA5, 8'h30, 8'h71 with `load_last` on the third word (macro off) → `mem[0..2]`=A5,30,71, `loaded_count`=3. `cpu_hold` falls after the third accept. `pc`=1 reads `opcode`=3, `arg`=0.
- Full load of 8 words with no `load_last` (macro off) → the state returns to IDLE after the 8th accept, and a 9th `load_valid` is ignored (`load_ready`=0).
- Macro on: send A5, 30, then a checksum word with low nibble A^5^3^0=4'hC → `load_error`=0. Repeat with checksum 4'hD → `load_error`=1, and it stays 1 until the next `load_start`.
- Pulse `load_start` after 2 words, then send 8'h11 → `mem[0]`=11, `loaded_count`=1, and the old `mem[1]` is unchanged.
- Assert `reset` in LOAD after 4 words → `cpu_hold`, `load_ready` and `loaded_count` are 0 immediately, and all addresses read 0.
